// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial shifter with a one-word holding register,
//               giving a gap-free bit stream for back-to-back words.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic               r_sout;
    logic               r_sout_valid;
    logic               r_frame_start;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   w_shift_adv;
    logic [WIDTH-1:0]   w_hold_nxt;
    logic               w_hold_full_nxt;
    logic               w_load;
    logic               w_head;
    logic               w_accept;
    logic               w_load_slot;

    assign in_ready    = !r_hold_full;
    assign w_accept    = in_valid && !r_hold_full;
    assign w_load_slot = (r_state == S_IDLE) || (r_cnt == c_LAST);

    // The head bit is whichever end of the shifter leaves first.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head      = w_shift_nxt[WIDTH-1];
            assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head      = w_shift_nxt[0];
            assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_load          = 1'b0;

        if (w_load_slot) begin
            // A held word always has priority; accept is impossible while it is full.
            if (r_hold_full) begin
                w_load          = 1'b1;
                w_shift_nxt     = r_hold;
                w_hold_full_nxt = 1'b0;
            end else if (w_accept) begin
                w_load      = 1'b1;
                w_shift_nxt = in_data;
            end else begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_shift_nxt = '0;
            end
            if (w_load) begin
                w_state_nxt = S_SHIFT;
                w_cnt_nxt   = '0;
            end
        end else begin
            w_cnt_nxt   = r_cnt + c_CNT_W'(1);
            w_shift_nxt = w_shift_adv;
            if (w_accept) begin
                w_hold_nxt      = in_data;
                w_hold_full_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_sout        <= 1'b0;
            r_sout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_hold        <= w_hold_nxt;
            r_hold_full   <= w_hold_full_nxt;
            r_sout        <= (w_state_nxt == S_SHIFT) && w_head;
            r_sout_valid  <= (w_state_nxt == S_SHIFT);
            r_frame_start <= w_load;
            r_busy        <= (w_state_nxt == S_SHIFT) || w_hold_full_nxt;
        end
    end

    assign sout        = r_sout;
    assign sout_valid  = r_sout_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule
`default_nettype wire
